sfm_row_scheduler: RTL and testbench



---
 rtl/sfm_pkg.sv | 40 ++++
 rtl/sfm_sched_addr_gen.sv | 44 ++++
 rtl/sfm_row_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_sfm_row_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfm_pkg.sv
// Shared types for the softmax row scheduler: state encoding, the
// configuration snapshot and the per-stream control bundle.
package sfm_pkg;

  localparam int unsigned SFM_ADDR_WIDTH = 32;
  localparam int unsigned SFM_LEN_WIDTH  = 32;
  localparam int unsigned SFM_ROW_WIDTH  = 16;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SETUP      = 4'd1,
    ST_ACC_START  = 4'd2,
    ST_ACC_WAIT   = 4'd3,
    ST_ACC_DRAIN  = 4'd4,
    ST_NORM_START = 4'd5,
    ST_NORM_WAIT  = 4'd6,
    ST_NEXT       = 4'd7,
    ST_FINISH     = 4'd8
  } sched_state_e;

  typedef struct packed {
    logic [SFM_ROW_WIDTH-1:0]  n_rows;
    logic [SFM_LEN_WIDTH-1:0]  row_len;
    logic [SFM_ADDR_WIDTH-1:0] in_addr;
    logic [SFM_ADDR_WIDTH-1:0] out_addr;
    logic [SFM_ADDR_WIDTH-1:0] stride;
  } sched_cfg_t;

  typedef struct packed {
    logic                      start;
    logic [SFM_ADDR_WIDTH-1:0] addr;
    logic [SFM_LEN_WIDTH-1:0]  len;
  } sched_stream_ctrl_t;

  // A job with no rows or no elements per row has nothing to stream.
  function automatic logic cfg_is_empty(input sched_cfg_t cfg);
    return (cfg.n_rows == '0) || (cfg.row_len == '0);
  endfunction

endpackage

// File: rtl/sfm_sched_addr_gen.sv
// Row address generator: loads the input/output bases and the shared row
// stride at job launch, then advances both addresses by one stride per step.
module sfm_sched_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] in_base_i,
  input  logic [ADDR_WIDTH-1:0] out_base_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ADDR_WIDTH-1:0] in_addr_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o
);

  logic [ADDR_WIDTH-1:0] in_addr_r;
  logic [ADDR_WIDTH-1:0] out_addr_r;
  logic [ADDR_WIDTH-1:0] stride_r;

  // Address registers: load wins over step; the sum wraps silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_addr_r  <= '0;
      out_addr_r <= '0;
      stride_r   <= '0;
    end else if (load_i) begin
      in_addr_r  <= in_base_i;
      out_addr_r <= out_base_i;
      stride_r   <= stride_i;
    end else if (step_i) begin
      in_addr_r  <= in_addr_r + stride_r;
      out_addr_r <= out_addr_r + stride_r;
    end else begin
      in_addr_r  <= in_addr_r;
      out_addr_r <= out_addr_r;
      stride_r   <= stride_r;
    end
  end

  assign in_addr_o  = in_addr_r;
  assign out_addr_o = out_addr_r;

endmodule

// File: rtl/sfm_row_scheduler.sv
// Softmax row scheduler: walks a 2-D tile row by row, running an
// accumulate pass (stream in, reduce) then a normalize pass (stream in and
// out) per row. All outputs are registered, decoded from the next state so
// they line up with the state they belong to.
module sfm_row_scheduler
  import sfm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SFM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = SFM_LEN_WIDTH,
  parameter int unsigned ROW_WIDTH  = SFM_ROW_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ROW_WIDTH-1:0]  cfg_n_rows_i,
  input  logic [LEN_WIDTH-1:0]  cfg_row_len_i,
  input  logic [ADDR_WIDTH-1:0] cfg_in_addr_i,
  input  logic [ADDR_WIDTH-1:0] cfg_out_addr_i,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
  output logic                  in_start_o,
  output logic [ADDR_WIDTH-1:0] in_addr_o,
  output logic [LEN_WIDTH-1:0]  in_len_o,
  input  logic                  in_done_i,
  output logic                  out_start_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [LEN_WIDTH-1:0]  out_len_o,
  input  logic                  out_done_i,
  output logic                  dp_clear_o,
  output logic                  dp_acc_o,
  input  logic                  dp_idle_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ROW_WIDTH-1:0]  row_cnt_o
);

  sched_state_e state_r, state_next_s;

  sched_cfg_t         cfg_s;
  sched_stream_ctrl_t in_ctrl_s, out_ctrl_s;

  logic [ROW_WIDTH-1:0]  n_rows_r;
  logic [LEN_WIDTH-1:0]  row_len_r;
  logic [ROW_WIDTH-1:0]  row_cnt_r;
  logic                  in_seen_r, out_seen_r;
  logic                  in_start_r, out_start_r, dp_clear_r, dp_acc_r;
  logic                  busy_r, done_r;
  logic [ADDR_WIDTH-1:0] in_addr_s, out_addr_s;

  logic start_take_s;
  logic abort_take_s;
  logic step_s;
  logic last_row_s;
  logic pair_done_s;

  assign cfg_s.n_rows   = cfg_n_rows_i;
  assign cfg_s.row_len  = cfg_row_len_i;
  assign cfg_s.in_addr  = cfg_in_addr_i;
  assign cfg_s.out_addr = cfg_out_addr_i;
  assign cfg_s.stride   = cfg_stride_i;

  // Start only counts from IDLE; abort only counts outside IDLE, so a
  // simultaneous start and abort in IDLE launches the job.
  assign start_take_s = (state_r == ST_IDLE) && start_i;
  assign abort_take_s = (state_r != ST_IDLE) && abort_i;
  assign step_s       = (state_r == ST_NEXT) && !abort_take_s;
  assign last_row_s   = ((row_cnt_r + ROW_WIDTH'(1)) == n_rows_r);
  // The pair completes when each done is either remembered or arriving now.
  assign pair_done_s  = (in_seen_r || in_done_i) && (out_seen_r || out_done_i);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    state_next_s = state_r;
    if (abort_take_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            if (cfg_is_empty(cfg_s)) begin
              state_next_s = ST_FINISH;
            end else begin
              state_next_s = ST_SETUP;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SETUP:      state_next_s = ST_ACC_START;
        ST_ACC_START:  state_next_s = ST_ACC_WAIT;
        ST_ACC_WAIT: begin
          if (in_done_i) begin
            state_next_s = ST_ACC_DRAIN;
          end else begin
            state_next_s = ST_ACC_WAIT;
          end
        end
        ST_ACC_DRAIN: begin
          if (dp_idle_i) begin
            state_next_s = ST_NORM_START;
          end else begin
            state_next_s = ST_ACC_DRAIN;
          end
        end
        ST_NORM_START: state_next_s = ST_NORM_WAIT;
        ST_NORM_WAIT: begin
          if (pair_done_s) begin
            state_next_s = ST_NEXT;
          end else begin
            state_next_s = ST_NORM_WAIT;
          end
        end
        ST_NEXT: begin
          if (last_row_s) begin
            state_next_s = ST_FINISH;
          end else begin
            state_next_s = ST_SETUP;
          end
        end
        ST_FINISH:     state_next_s = ST_IDLE;
        default:       state_next_s = ST_IDLE;
      endcase
    end
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_start_r  <= 1'b0;
      out_start_r <= 1'b0;
      dp_clear_r  <= 1'b0;
      dp_acc_r    <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      in_start_r  <= (state_next_s == ST_ACC_START) || (state_next_s == ST_NORM_START);
      out_start_r <= (state_next_s == ST_NORM_START);
      dp_clear_r  <= (state_next_s == ST_SETUP) || abort_take_s;
      dp_acc_r    <= !((state_next_s == ST_NORM_START) ||
                       (state_next_s == ST_NORM_WAIT)  ||
                       (state_next_s == ST_NEXT));
      busy_r      <= (state_next_s != ST_IDLE);
      done_r      <= (state_next_s == ST_FINISH);
    end
  end

  // Job geometry latched at launch so mid-job cfg changes are invisible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_rows_r  <= '0;
      row_len_r <= '0;
    end else if (start_take_s) begin
      n_rows_r  <= cfg_s.n_rows;
      row_len_r <= cfg_s.row_len;
    end else begin
      n_rows_r  <= n_rows_r;
      row_len_r <= row_len_r;
    end
  end

  // Completed-row counter: cleared at launch, bumped once per NEXT, held on abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_cnt_r <= '0;
    end else if (start_take_s) begin
      row_cnt_r <= '0;
    end else if (step_s) begin
      row_cnt_r <= row_cnt_r + ROW_WIDTH'(1);
    end else begin
      row_cnt_r <= row_cnt_r;
    end
  end

  // Sticky done flags live only inside NORM_WAIT and clear on its exit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_seen_r  <= 1'b0;
      out_seen_r <= 1'b0;
    end else if ((state_r == ST_NORM_WAIT) && !pair_done_s && !abort_take_s) begin
      in_seen_r  <= in_seen_r  || in_done_i;
      out_seen_r <= out_seen_r || out_done_i;
    end else begin
      in_seen_r  <= 1'b0;
      out_seen_r <= 1'b0;
    end
  end

  sfm_sched_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (start_take_s),
    .step_i     (step_s),
    .in_base_i  (cfg_s.in_addr),
    .out_base_i (cfg_s.out_addr),
    .stride_i   (cfg_s.stride),
    .in_addr_o  (in_addr_s),
    .out_addr_o (out_addr_s)
  );

  assign in_ctrl_s.start  = in_start_r;
  assign in_ctrl_s.addr   = in_addr_s;
  assign in_ctrl_s.len    = row_len_r;
  assign out_ctrl_s.start = out_start_r;
  assign out_ctrl_s.addr  = out_addr_s;
  assign out_ctrl_s.len   = row_len_r;

  assign in_start_o  = in_ctrl_s.start;
  assign in_addr_o   = in_ctrl_s.addr;
  assign in_len_o    = in_ctrl_s.len;
  assign out_start_o = out_ctrl_s.start;
  assign out_addr_o  = out_ctrl_s.addr;
  assign out_len_o   = out_ctrl_s.len;
  assign dp_clear_o  = dp_clear_r;
  assign dp_acc_o    = dp_acc_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign row_cnt_o   = row_cnt_r;

endmodule

// File: tb/tb_sfm_row_scheduler.sv
// Directed bench for the softmax row scheduler. A small stream/datapath
// responder inside tick() answers start pulses with done pulses after a
// programmable delay, and logs addresses seen at each start.
module tb_sfm_row_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, abort_i;
  logic [15:0] cfg_n_rows_i;
  logic [31:0] cfg_row_len_i, cfg_in_addr_i, cfg_out_addr_i, cfg_stride_i;
  logic        in_start_o, out_start_o, in_done_i, out_done_i;
  logic [31:0] in_addr_o, in_len_o, out_addr_o, out_len_o;
  logic        dp_clear_o, dp_acc_o, dp_idle_i, busy_o, done_o;
  logic [15:0] row_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  int in_dly, out_dly, idle_en;
  int in_cnt, out_cnt, idle_cnt;
  int n_in, n_out, n_done, n_clear, n_busy, n_acc;
  logic [31:0] in_log  [16];
  logic [31:0] out_log [16];
  logic [15:0] row_log [16];

  always #5 clk_i = ~clk_i;

  sfm_row_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_n_rows_i(cfg_n_rows_i), .cfg_row_len_i(cfg_row_len_i),
    .cfg_in_addr_i(cfg_in_addr_i), .cfg_out_addr_i(cfg_out_addr_i),
    .cfg_stride_i(cfg_stride_i),
    .in_start_o(in_start_o), .in_addr_o(in_addr_o), .in_len_o(in_len_o),
    .in_done_i(in_done_i),
    .out_start_o(out_start_o), .out_addr_o(out_addr_o), .out_len_o(out_len_o),
    .out_done_i(out_done_i),
    .dp_clear_o(dp_clear_o), .dp_acc_o(dp_acc_o), .dp_idle_i(dp_idle_i),
    .busy_o(busy_o), .done_o(done_o), .row_cnt_o(row_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_in = 0; n_out = 0; n_done = 0; n_clear = 0; n_busy = 0; n_acc = 0;
    in_cnt = 0; out_cnt = 0; idle_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_log[i] = '0; out_log[i] = '0; row_log[i] = '0;
    end
  endtask

  // Advance one clock, then sample outputs and drive responder inputs.
  task automatic tick();
    @(posedge clk_i);
    #1;
    in_done_i = 1'b0; out_done_i = 1'b0; dp_idle_i = 1'b0;
    if (idle_cnt > 0) begin
      idle_cnt--;
      if (idle_cnt == 0 && idle_en != 0) dp_idle_i = 1'b1;
    end
    if (in_cnt > 0) begin
      in_cnt--;
      if (in_cnt == 0) begin in_done_i = 1'b1; idle_cnt = 2; end
    end
    if (out_cnt > 0) begin
      out_cnt--;
      if (out_cnt == 0) out_done_i = 1'b1;
    end
    if (in_start_o) begin
      in_cnt = in_dly;
      if (n_in < 16) in_log[n_in] = in_addr_o;
      n_in++;
      if (dp_acc_o) begin
        if (n_acc < 16) row_log[n_acc] = row_cnt_o;
        n_acc++;
      end
    end
    if (out_start_o) begin
      out_cnt = out_dly;
      if (n_out < 16) out_log[n_out] = out_addr_o;
      n_out++;
    end
    if (done_o) n_done++;
    if (dp_clear_o) n_clear++;
    if (busy_o) n_busy++;
  endtask

  task automatic set_cfg(input logic [15:0] nr, input logic [31:0] len,
                         input logic [31:0] ia, input logic [31:0] oa, input logic [31:0] st);
    cfg_n_rows_i = nr; cfg_row_len_i = len; cfg_in_addr_i = ia;
    cfg_out_addr_i = oa; cfg_stride_i = st;
  endtask

  // Pulse start for one edge; on return the DUT is in cycle 1 of the job.
  task automatic start_job();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_job(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && busy_o; i++) tick();
    check_eq({tag, "_ended"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    in_done_i = 1'b0; out_done_i = 1'b0; dp_idle_i = 1'b0;
    in_dly = 5; out_dly = 5; idle_en = 1;
    set_cfg(16'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    clear_stats();
    repeat (3) tick();
    check_eq("rst_busy",  {63'd0, busy_o}, 64'd0);
    check_eq("rst_acc",   {63'd0, dp_acc_o}, 64'd1);
    check_eq("rst_pulses", {60'd0, in_start_o, out_start_o, dp_clear_o, done_o}, 64'd0);
    check_eq("rst_rowcnt", {48'd0, row_cnt_o}, 64'd0);
    check_eq("rst_addr",  {in_addr_o, out_addr_o}, 64'd0);
    check_eq("rst_len",   {in_len_o, out_len_o}, 64'd0);
    rst_i = 1'b0;
    tick();

    // Main three-row job with latency checks at the front.
    clear_stats();
    set_cfg(16'd3, 32'd8, 32'h1000, 32'h2000, 32'h40);
    start_job();
    check_eq("c1_clear", {62'd0, dp_clear_o, in_start_o}, 64'h2);
    check_eq("c1_busy",  {62'd0, busy_o, dp_acc_o}, 64'h3);
    tick();
    check_eq("c2_instart", {62'd0, in_start_o, dp_clear_o}, 64'h2);
    check_eq("c2_inaddr", {32'd0, in_addr_o}, 64'h1000);
    run_job("main", 300);
    check_eq("main_nin",  n_in, 6);
    check_eq("main_in_addrs", {in_log[0], in_log[1]}, {32'h1000, 32'h1000});
    check_eq("main_in_addrs2", {in_log[2], in_log[3]}, {32'h1040, 32'h1040});
    check_eq("main_in_addrs3", {in_log[4], in_log[5]}, {32'h1080, 32'h1080});
    check_eq("main_nout", n_out, 3);
    check_eq("main_out_addrs", {out_log[0], out_log[2]}, {32'h2000, 32'h2080});
    check_eq("main_ndone", n_done, 1);
    check_eq("main_nclear", n_clear, 3);
    check_eq("main_rowcnt", {48'd0, row_cnt_o}, 64'd3);
    check_eq("main_len", {in_len_o, out_len_o}, {32'd8, 32'd8});

    // Empty jobs: zero rows, then zero row length.
    for (int k = 0; k < 2; k++) begin
      clear_stats();
      if (k == 0) set_cfg(16'd0, 32'd8, 32'h10, 32'h20, 32'h4);
      else        set_cfg(16'd4, 32'd0, 32'h10, 32'h20, 32'h4);
      start_job();
      check_eq("empty_c1", {62'd0, done_o, busy_o}, 64'h3);
      tick();
      check_eq("empty_c2", {62'd0, done_o, busy_o}, 64'h0);
      tick();
      check_eq("empty_starts", n_in + n_out, 0);
      check_eq("empty_busy_cycles", n_busy, 1);
      check_eq("empty_ndone", n_done, 1);
      check_eq("empty_rowcnt", {48'd0, row_cnt_o}, 64'd0);
    end

    // NORM_WAIT ordering: out_done first, then both in the same cycle.
    for (int k = 0; k < 2; k++) begin
      clear_stats();
      if (k == 0) begin in_dly = 6; out_dly = 3; end
      else        begin in_dly = 5; out_dly = 5; end
      set_cfg(16'd2, 32'd4, 32'h400, 32'h800, 32'h20);
      start_job();
      run_job("order", 300);
      check_eq("order_rowlog", {row_log[0], row_log[1]}, {16'd0, 16'd1});
      check_eq("order_rowcnt", {48'd0, row_cnt_o}, 64'd2);
      check_eq("order_ndone", n_done, 1);
      check_eq("order_nout", n_out, 2);
    end
    in_dly = 5; out_dly = 5;

    // Abort while draining row 2, then a clean one-row job.
    clear_stats();
    set_cfg(16'd3, 32'd8, 32'h1000, 32'h2000, 32'h40);
    start_job();
    for (int i = 0; i < 200 && n_in < 3; i++) tick();
    check_eq("abort_reach", n_in, 3);
    idle_en = 0;
    repeat (6) tick();
    check_eq("abort_drain", {62'd0, busy_o, dp_acc_o}, 64'h3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_eq("abort_idle", {61'd0, busy_o, dp_clear_o, done_o}, 64'h2);
    check_eq("abort_rowcnt", {48'd0, row_cnt_o}, 64'd1);
    tick();
    check_eq("abort_after", {62'd0, dp_clear_o, busy_o}, 64'h0);
    check_eq("abort_ndone", n_done, 0);
    idle_en = 1;
    clear_stats();
    set_cfg(16'd1, 32'd2, 32'h3000, 32'h5000, 32'h8);
    start_job();
    run_job("post_abort", 200);
    check_eq("post_abort_log", {in_log[0], in_log[1]}, {32'h3000, 32'h3000});
    check_eq("post_abort_done", {n_done, 16'd0, row_cnt_o}, {32'd1, 16'd0, 16'd1});

    // Start re-pulse and cfg change mid-job are ignored.
    clear_stats();
    set_cfg(16'd2, 32'd4, 32'h100, 32'h300, 32'h10);
    start_job();
    repeat (4) tick();
    set_cfg(16'd5, 32'd9, 32'h9000, 32'h9900, 32'h100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_job("midjob", 300);
    check_eq("midjob_in", {in_log[2], in_log[3]}, {32'h110, 32'h110});
    check_eq("midjob_out", {out_log[0], out_log[1]}, {32'h300, 32'h310});
    check_eq("midjob_cnt", {n_in, 16'd0, row_cnt_o}, {32'd4, 16'd0, 16'd2});
    check_eq("midjob_len", {32'd0, in_len_o}, 64'd4);

    // Input address wraps past the top of the address space.
    clear_stats();
    set_cfg(16'd2, 32'd4, 32'hFFFF_FFC0, 32'h10, 32'h40);
    start_job();
    run_job("wrap", 300);
    check_eq("wrap_in", {in_log[1], in_log[2]}, {32'hFFFF_FFC0, 32'h0});
    check_eq("wrap_out", {32'd0, out_log[1]}, 64'h50);
    check_eq("wrap_done", {n_done, 16'd0, row_cnt_o}, {32'd1, 16'd0, 16'd2});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
